memory_responder: RTL and testbench

//  Word-addressed memory slave that serves the processor data path's READ/WRITE

---
 rtl/memory_responder.sv | 159 +++++++++++++++
 tb/tb_memory_responder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - word-addressed memory slave with wait states and READY handshake
module memory_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int WAIT_STATES    = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  READY,
  output logic                  ERR
);

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  // Counter value on the last WAIT cycle; meaningless (and unused) when WAIT_STATES is 0.
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic                        op_write_q, op_write_d;
  logic [MEM_DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]       dout_q, dout_d;
  logic                        ready_q, ready_d;
  logic                        err_q, err_d;

  // Access performed on the edge that enters ACK.
  logic                        acc_go;
  logic                        acc_write;
  logic [MEM_DEPTH_LOG2-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]       acc_data;
  logic                        mem_we;
  logic                        op_strobe;

  logic [DATA_WIDTH-1:0]       mem [DEPTH];

  // Upper address bits alias; they are intentionally not decoded.
  logic                        unused_addr_hi;
  assign unused_addr_hi = ^ADDR[ADDR_WIDTH-1:MEM_DEPTH_LOG2];

  assign DATA_OUT = dout_q;
  assign READY    = ready_q;
  assign ERR      = err_q;

  // Next-state, request latching and access selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dout_d     = dout_q;
    ready_d    = ready_q;
    err_d      = 1'b0;
    acc_go     = 1'b0;
    acc_write  = op_write_q;
    acc_addr   = addr_q;
    acc_data   = wdata_q;
    mem_we     = 1'b0;
    op_strobe  = op_write_q ? WRITE : READ;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b0;
        if (READ && WRITE) begin
          err_d = 1'b1;
        end else if (READ || WRITE) begin
          op_write_d = WRITE;
          addr_d     = ADDR[MEM_DEPTH_LOG2-1:0];
          wdata_d    = DATA_IN;
          cnt_d      = 4'd0;
          if (WAIT_STATES == 0) begin
            // No wait states: access straight from the bus on the sampling edge.
            state_d   = S_ACK;
            ready_d   = 1'b1;
            acc_go    = 1'b1;
            acc_write = WRITE;
            acc_addr  = ADDR[MEM_DEPTH_LOG2-1:0];
            acc_data  = DATA_IN;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!op_strobe) begin
          // Processor abandoned the request: no access, back to IDLE.
          state_d = S_IDLE;
        end else if (cnt_q == LAST_WAIT) begin
          state_d = S_ACK;
          ready_d = 1'b1;
          acc_go  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ACK: begin
        if (!READ && !WRITE) begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
      end
    endcase

    if (acc_go) begin
      if (acc_write) begin
        mem_we = 1'b1;
      end else begin
        dout_d = mem[acc_addr];
      end
    end
  end

  // Control and output registers; reset discards any pending access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dout_q     <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dout_q     <= dout_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  // Storage array; contents survive reset, but reset blocks a write on the same edge.
  always_ff @(posedge CLK) begin
    if (!RST && mem_we) begin
      mem[acc_addr] <= acc_data;
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - directed self-checking bench for memory_responder
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_a, wr_a, rdy_a, err_a;
  logic [31:0] addr_a, din_a, dout_a;
  logic        rd_b, wr_b, rdy_b, err_b;
  logic [31:0] addr_b, din_b, dout_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  memory_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH_LOG2(10), .WAIT_STATES(2)) dut_a (
    .CLK(clk), .RST(rst), .READ(rd_a), .WRITE(wr_a), .ADDR(addr_a), .DATA_IN(din_a),
    .DATA_OUT(dout_a), .READY(rdy_a), .ERR(err_a)
  );

  memory_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH_LOG2(10), .WAIT_STATES(0)) dut_b (
    .CLK(clk), .RST(rst), .READ(rd_b), .WRITE(wr_b), .ADDR(addr_b), .DATA_IN(din_b),
    .DATA_OUT(dout_b), .READY(rdy_b), .ERR(err_b)
  );

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit b, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (b) begin
      rd_b = r; wr_b = w; addr_b = a; din_b = d;
    end else begin
      rd_a = r; wr_a = w; addr_a = a; din_a = d;
    end
  endtask

  function automatic logic get_rdy(input bit b);
    return b ? rdy_b : rdy_a;
  endfunction

  function automatic logic [31:0] get_dout(input bit b);
    return b ? dout_b : dout_a;
  endfunction

  // Full request/handshake; lat is the expected edge count from strobe to READY.
  task automatic xact(input bit b, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input int lat, input logic [31:0] exp_dout, input string name);
    int n;
    n = 0;
    drive(b, !w, w, a, d);
    while (n < 20) begin
      tick();
      n++;
      if (get_rdy(b)) break;
      // Bus changes after the request is latched must be ignored.
      drive(b, !w, w, a ^ 32'h0000_00F0, ~d);
    end
    check({name, " latency"}, n, lat);
    check({name, " dout"}, get_dout(b), exp_dout);
    tick();
    check({name, " ready held"}, {31'd0, get_rdy(b)}, 32'd1);
    drive(b, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
    tick();
    check({name, " ready drop"}, {31'd0, get_rdy(b)}, 32'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 32'd5,          32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{1'b0, 32'd5,          32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'd0,          32'h0000_0000, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 32'd9,          32'h0000_0000, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 32'd3,          32'h0000_0333, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 32'h0000_0400,  32'h0000_0055, 32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 32'd0,          32'h0,         32'h0000_0055};
    vecs[7] = '{1'b1, 32'h0000_0012,  32'hCAFE_F00D, 32'h0000_0055};
    vecs[8] = '{1'b0, 32'h0000_0412,  32'h0,         32'hCAFE_F00D};
    vecs[9] = '{1'b0, 32'd3,          32'h0,         32'h0000_0333};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    check("reset dout_a", dout_a, 32'h0);
    check("reset ready_a", {31'd0, rdy_a}, 32'd0);
    check("reset err_a", {31'd0, err_a}, 32'd0);
    check("reset dout_b", dout_b, 32'h0);
    check("reset ready_b", {31'd0, rdy_b}, 32'd0);
    tick();

    // Two-wait-state table of transactions.
    for (int i = 0; i < 10; i++) begin
      xact(1'b0, vecs[i].w, vecs[i].addr, vecs[i].data, 3, vecs[i].exp_dout, $sformatf("vec%0d", i));
    end

    // Zero wait states.
    xact(1'b1, 1'b1, 32'd7, 32'h0000_0001, 1, 32'h0, "ws0 write");
    xact(1'b1, 1'b0, 32'd7, 32'h0, 1, 32'h0000_0001, "ws0 read");

    // Both strobes high in IDLE: ERR every cycle, no access.
    drive(1'b0, 1'b1, 1'b1, 32'd0, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("err cycle%0d", i), {31'd0, err_a}, 32'd1);
      check($sformatf("err ready%0d", i), {31'd0, rdy_a}, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
    tick();
    check("err clears", {31'd0, err_a}, 32'd0);
    xact(1'b0, 1'b0, 32'd0, 32'h0, 3, 32'h0000_0055, "read after err");

    // Write aborted after one WAIT cycle.
    drive(1'b0, 1'b0, 1'b1, 32'd9, 32'hA5A5_A5A5);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd9, 32'hA5A5_A5A5);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("abort noready%0d", i), {31'd0, rdy_a}, 32'd0);
    end
    check("abort dout", dout_a, 32'h0000_0055);
    xact(1'b0, 1'b0, 32'd9, 32'h0, 3, 32'h0000_0000, "read after abort");

    // Reset during WAIT of a write to address 3.
    xact(1'b0, 1'b0, 32'd5, 32'h0, 3, 32'hDEAD_BEEF, "read before rst");
    drive(1'b0, 1'b0, 1'b1, 32'd3, 32'h0000_0777);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
    check("rst wait ready", {31'd0, rdy_a}, 32'd0);
    check("rst wait err", {31'd0, err_a}, 32'd0);
    check("rst wait dout", dout_a, 32'h0);
    tick();
    check("rst idle ready", {31'd0, rdy_a}, 32'd0);
    xact(1'b0, 1'b0, 32'd3, 32'h0, 3, 32'h0000_0333, "read after rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
